// File: rtl/sa_raddr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sa_raddr_arbiter_pkg
// Shared definitions for the slave-side read-address arbiter:
//   - arb_state_e  : arbiter FSM states (IDLE, ISSUE)
//   - idx_w()      : width of a master index, never narrower than one bit
//   - pack_slv_id(): builds the slave-side ID {mst_idx, mst_id}
// No ports (package).
// -----------------------------------------------------------------------------
package sa_raddr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } arb_state_e;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Result is wide; callers keep the low TRANS_SLV_ID_W bits.
   function automatic logic [63:0] pack_slv_id(input logic [31:0] mst_idx,
                                               input logic [31:0] mst_id,
                                               input int unsigned mst_id_w);
      return ({32'd0, mst_idx} << mst_id_w) | {32'd0, mst_id};
   endfunction

endpackage

// File: rtl/sa_raddr_arbiter_if.sv
// -----------------------------------------------------------------------------
// sa_raddr_arbiter_if
// Bundles the dispatcher AR requests, the shared slave AR port and the
// ordering sideband towards sa_RDATA_channel. Signal suffixes are written
// from the arbiter's point of view.
//   modport slave  : the arbiter itself
//   modport master : the surrounding fabric (dispatchers, slave, RDATA channel)
// Signals:
//   dsp_ARID_i/ARADDR_i/ARLEN_i/ARVALID_i  per-master request, master i at slice i
//   dsp_ARREADY_o                          per-master ready, one-hot or zero
//   s_ARID_o/ARADDR_o/ARLEN_o/ARVALID_o    registered request to the slave
//   s_ARREADY_i                            slave ready
//   s_RLAST_hs_i                           one read retired at the slave
//   AR_AxID_o/AR_crossing_flag_o/AR_shift_en_o  ordering FIFO push
//   AR_stall_i                             ordering FIFO full
// -----------------------------------------------------------------------------
interface sa_raddr_arbiter_if
   import sa_raddr_arbiter_pkg::*;
#(
   parameter int MST_AMT        = 3,
   parameter int ADDR_WIDTH     = 32,
   parameter int LEN_WIDTH      = 8,
   parameter int TRANS_MST_ID_W = 5
);
   localparam int MST_ID_W       = idx_w(MST_AMT);
   localparam int TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W;

   logic [TRANS_MST_ID_W*MST_AMT-1:0] dsp_ARID_i;
   logic [ADDR_WIDTH*MST_AMT-1:0]     dsp_ARADDR_i;
   logic [LEN_WIDTH*MST_AMT-1:0]      dsp_ARLEN_i;
   logic [MST_AMT-1:0]                dsp_ARVALID_i;
   logic [MST_AMT-1:0]                dsp_ARREADY_o;

   logic [TRANS_SLV_ID_W-1:0]         s_ARID_o;
   logic [ADDR_WIDTH-1:0]             s_ARADDR_o;
   logic [LEN_WIDTH-1:0]              s_ARLEN_o;
   logic                              s_ARVALID_o;
   logic                              s_ARREADY_i;
   logic                              s_RLAST_hs_i;

   logic [TRANS_SLV_ID_W-1:0]         AR_AxID_o;
   logic                              AR_crossing_flag_o;
   logic                              AR_shift_en_o;
   logic                              AR_stall_i;

   modport slave (
      input  dsp_ARID_i, dsp_ARADDR_i, dsp_ARLEN_i, dsp_ARVALID_i,
      output dsp_ARREADY_o,
      output s_ARID_o, s_ARADDR_o, s_ARLEN_o, s_ARVALID_o,
      input  s_ARREADY_i, s_RLAST_hs_i,
      output AR_AxID_o, AR_crossing_flag_o, AR_shift_en_o,
      input  AR_stall_i
   );

   modport master (
      output dsp_ARID_i, dsp_ARADDR_i, dsp_ARLEN_i, dsp_ARVALID_i,
      input  dsp_ARREADY_o,
      input  s_ARID_o, s_ARADDR_o, s_ARLEN_o, s_ARVALID_o,
      output s_ARREADY_i, s_RLAST_hs_i,
      input  AR_AxID_o, AR_crossing_flag_o, AR_shift_en_o,
      output AR_stall_i
   );

endinterface

// File: rtl/sa_raddr_arbiter_rr.sv
// -----------------------------------------------------------------------------
// sa_raddr_arbiter_rr
// Combinational round-robin picker: the winner is the first asserted request
// found searching upward from ptr_i, wrapping from MST_AMT-1 back to 0.
// Ports:
//   req_i  in  MST_AMT   request vector
//   ptr_i  in  MST_ID_W  highest-priority index
//   gnt_o  out MST_AMT   one-hot winner (zero when no request)
//   idx_o  out MST_ID_W  binary winner index
//   any_o  out 1         at least one request
// -----------------------------------------------------------------------------
module sa_raddr_arbiter_rr #(
   parameter int MST_AMT  = 3,
   parameter int MST_ID_W = 2
) (
   input  logic [MST_AMT-1:0]  req_i,
   input  logic [MST_ID_W-1:0] ptr_i,
   output logic [MST_AMT-1:0]  gnt_o,
   output logic [MST_ID_W-1:0] idx_o,
   output logic                any_o
);

   int cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      cand  = 0;
      for (int k = 0; k < MST_AMT; k++) begin
         cand = int'(ptr_i) + k;
         if (cand >= MST_AMT) cand = cand - MST_AMT;
         if (!any_o && req_i[cand]) begin
            any_o       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = MST_ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/sa_raddr_arbiter.sv
// -----------------------------------------------------------------------------
// sa_raddr_arbiter
// Shares one slave AR port among MST_AMT dispatchers with round-robin
// priority. The winning request is registered and presented to the slave with
// its ID widened to {mst_idx, ARID}. At most OUTSTANDING_AMT reads may be
// issued and not yet retired. Each slave handshake pushes the ordering
// sideband (ID, crossing flag) to sa_RDATA_channel, whose full flag
// (AR_stall_i) blocks new grants but never a request already presented.
// Ports:
//   ACLK_i     in  clock
//   ARESETn_i  in  asynchronous reset, active low
//   bus        sa_raddr_arbiter_if.slave (request, slave port, sideband)
// -----------------------------------------------------------------------------
module sa_raddr_arbiter
   import sa_raddr_arbiter_pkg::*;
#(
   parameter int MST_AMT         = 3,
   parameter int OUTSTANDING_AMT = 8,
   parameter int ADDR_WIDTH      = 32,
   parameter int LEN_WIDTH       = 8,
   parameter int TRANS_MST_ID_W  = 5
) (
   input  logic              ACLK_i,
   input  logic              ARESETn_i,
   sa_raddr_arbiter_if.slave bus
);

   localparam int MST_ID_W       = idx_w(MST_AMT);
   localparam int TRANS_SLV_ID_W = TRANS_MST_ID_W + MST_ID_W;
   localparam int CNT_W          = $clog2(OUTSTANDING_AMT + 1);

   arb_state_e                state_q, state_d;
   logic                      s_arvalid_q, s_arvalid_d;
   logic [TRANS_SLV_ID_W-1:0] id_q, id_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [LEN_WIDTH-1:0]      len_q, len_d;
   logic [MST_ID_W-1:0]       rr_ptr_q, rr_ptr_d;
   logic [MST_ID_W-1:0]       last_mst_q, last_mst_d;
   logic [CNT_W-1:0]          out_cnt_q, out_cnt_d;

   logic [MST_AMT-1:0]        win_gnt;
   logic [MST_ID_W-1:0]       win_idx;
   logic                      win_any;
   logic                      can_grant;
   logic                      hs;
   logic                      retire;
   logic [MST_ID_W-1:0]       iss_idx;
   logic [63:0]               packed_id;

   sa_raddr_arbiter_rr #(
      .MST_AMT  (MST_AMT),
      .MST_ID_W (MST_ID_W)
   ) u_rr (
      .req_i (bus.dsp_ARVALID_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (win_gnt),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   // Reset gating keeps ARREADY low while reset is held even if requests are up.
   assign can_grant = ARESETn_i && (state_q == IDLE) && win_any && !bus.AR_stall_i &&
                      (out_cnt_q < CNT_W'(OUTSTANDING_AMT));
   assign hs        = s_arvalid_q & bus.s_ARREADY_i;
   assign iss_idx   = id_q[TRANS_SLV_ID_W-1 -: MST_ID_W];
   // A retire with nothing outstanding is spurious and dropped.
   assign retire    = bus.s_RLAST_hs_i & (out_cnt_q != '0);

   always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
      if (!ARESETn_i) begin
         state_q     <= IDLE;
         s_arvalid_q <= 1'b0;
         id_q        <= '0;
         addr_q      <= '0;
         len_q       <= '0;
         rr_ptr_q    <= '0;
         last_mst_q  <= '0;
         out_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         s_arvalid_q <= s_arvalid_d;
         id_q        <= id_d;
         addr_q      <= addr_d;
         len_q       <= len_d;
         rr_ptr_q    <= rr_ptr_d;
         last_mst_q  <= last_mst_d;
         out_cnt_q   <= out_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      s_arvalid_d = s_arvalid_q;
      id_d        = id_q;
      addr_d      = addr_q;
      len_d       = len_q;
      rr_ptr_d    = rr_ptr_q;
      last_mst_d  = last_mst_q;
      packed_id   = pack_slv_id(32'(win_idx),
                                32'(bus.dsp_ARID_i[int'(win_idx)*TRANS_MST_ID_W +: TRANS_MST_ID_W]),
                                TRANS_MST_ID_W);
      case (state_q)
         IDLE: begin
            if (can_grant) begin
               state_d     = ISSUE;
               s_arvalid_d = 1'b1;
               id_d        = packed_id[TRANS_SLV_ID_W-1:0];
               addr_d      = bus.dsp_ARADDR_i[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               len_d       = bus.dsp_ARLEN_i[int'(win_idx)*LEN_WIDTH +: LEN_WIDTH];
            end
         end
         ISSUE: begin
            if (hs) begin
               state_d     = IDLE;
               s_arvalid_d = 1'b0;
               last_mst_d  = iss_idx;
               // Priority moves to the master after the one just served.
               rr_ptr_d    = (iss_idx == MST_ID_W'(MST_AMT - 1)) ? '0 : iss_idx + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (hs && !retire)      out_cnt_d = out_cnt_q + 1'b1;
      else if (!hs && retire) out_cnt_d = out_cnt_q - 1'b1;
   end

   assign bus.dsp_ARREADY_o      = can_grant ? win_gnt : '0;
   assign bus.s_ARID_o           = id_q;
   assign bus.s_ARADDR_o         = addr_q;
   assign bus.s_ARLEN_o          = len_q;
   assign bus.s_ARVALID_o        = s_arvalid_q;
   assign bus.AR_shift_en_o      = hs;
   assign bus.AR_AxID_o          = hs ? id_q : '0;
   assign bus.AR_crossing_flag_o = hs & (out_cnt_q != '0) & (iss_idx != last_mst_q);

endmodule

// File: tb/tb_sa_raddr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sa_raddr_arbiter
// Directed scenarios plus randomized traffic, every cycle compared against a
// transaction-level reference model (pending request, rotating priority,
// outstanding count).
// -----------------------------------------------------------------------------
module tb_sa_raddr_arbiter;
   import sa_raddr_arbiter_pkg::*;

   localparam int M   = 3;
   localparam int OUT = 8;
   localparam int AW  = 32;
   localparam int LW  = 8;
   localparam int IDW = 5;
   localparam int MW  = idx_w(M);
   localparam int SW  = IDW + MW;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sa_raddr_arbiter_if #(.MST_AMT(M), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TRANS_MST_ID_W(IDW)) bus ();

   sa_raddr_arbiter #(
      .MST_AMT(M), .OUTSTANDING_AMT(OUT), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .TRANS_MST_ID_W(IDW)
   ) dut (
      .ACLK_i    (clk),
      .ARESETn_i (rst_n),
      .bus       (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one pending request, priority pointer, outstanding reads.
   bit              m_busy;
   int              m_idx, m_rr, m_last, m_cnt;
   logic [IDW-1:0]  m_arid;
   logic [AW-1:0]   m_addr;
   logic [LW-1:0]   m_len;

   // Observations from the most recent step.
   logic [M-1:0]    o_rdy;
   logic [SW-1:0]   o_arid;
   logic            o_shift, o_cross;
   int              o_win;

   task automatic model_reset();
      m_busy = 0; m_idx = 0; m_rr = 0; m_last = 0; m_cnt = 0;
      m_arid = '0; m_addr = '0; m_len = '0;
   endtask

   task automatic inputs_idle();
      bus.dsp_ARVALID_i = '0;
      bus.s_ARREADY_i   = 1'b0;
      bus.s_RLAST_hs_i  = 1'b0;
      bus.AR_stall_i    = 1'b0;
   endtask

   task automatic step();
      int            w;
      logic [M-1:0]  e_rdy;
      logic [SW-1:0] e_id;
      bit            e_hs, e_cross, ret;
      logic [IDW-1:0] n_arid;
      logic [AW-1:0]  n_addr;
      logic [LW-1:0]  n_len;
      @(negedge clk);
      w = -1; e_rdy = '0; n_arid = '0; n_addr = '0; n_len = '0;
      if (!m_busy && m_cnt < OUT && !bus.AR_stall_i)
         for (int k = 0; k < M; k++)
            if (w < 0 && bus.dsp_ARVALID_i[(m_rr + k) % M]) w = (m_rr + k) % M;
      if (w >= 0) begin
         e_rdy[w] = 1'b1;
         n_arid = bus.dsp_ARID_i[w*IDW +: IDW];
         n_addr = bus.dsp_ARADDR_i[w*AW +: AW];
         n_len  = bus.dsp_ARLEN_i[w*LW +: LW];
      end
      e_id    = {MW'(m_idx), m_arid};
      e_hs    = m_busy && bus.s_ARREADY_i;
      e_cross = e_hs && m_cnt != 0 && m_idx != m_last;
      ret     = bus.s_RLAST_hs_i;
      o_rdy   = bus.dsp_ARREADY_o;
      o_arid  = bus.s_ARID_o;
      o_shift = bus.AR_shift_en_o;
      o_cross = bus.AR_crossing_flag_o;
      o_win   = -1;
      for (int k = 0; k < M; k++) if (o_rdy[k]) o_win = k;
      chk("arready",  64'(o_rdy), 64'(e_rdy));
      chk("arvalid",  64'(bus.s_ARVALID_o), 64'(m_busy));
      chk("arid",     64'(o_arid), 64'(e_id));
      chk("araddr",   64'(bus.s_ARADDR_o), 64'(m_addr));
      chk("arlen",    64'(bus.s_ARLEN_o), 64'(m_len));
      chk("shift_en", 64'(o_shift), 64'(e_hs));
      chk("axid",     64'(bus.AR_AxID_o), e_hs ? 64'(e_id) : 64'd0);
      chk("crossing", 64'(o_cross), 64'(e_cross));
      @(posedge clk);
      if (e_hs) begin
         m_busy = 0; m_last = m_idx; m_rr = (m_idx + 1) % M;
      end
      m_cnt = m_cnt + (e_hs ? 1 : 0) - ((ret && m_cnt > 0) ? 1 : 0);
      if (w >= 0) begin
         m_busy = 1; m_idx = w; m_arid = n_arid; m_addr = n_addr; m_len = n_len;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.dsp_ARVALID_i = '1;
      bus.AR_stall_i    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_arready", 64'(bus.dsp_ARREADY_o), 64'd0);
      chk("rst_arvalid", 64'(bus.s_ARVALID_o), 64'd0);
      chk("rst_arid",    64'(bus.s_ARID_o), 64'd0);
      chk("rst_shift",   64'(bus.AR_shift_en_o), 64'd0);
      inputs_idle();
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic rand_payload();
      for (int i = 0; i < M; i++) begin
         bus.dsp_ARID_i[i*IDW +: IDW] = IDW'($urandom);
         bus.dsp_ARADDR_i[i*AW +: AW] = $urandom;
         bus.dsp_ARLEN_i[i*LW +: LW]  = LW'($urandom);
      end
   endtask

   int gq[$];
   int cq[$];
   int ngr, nsh;
   logic [SW-1:0] ref_id;
   int exp_g[4] = '{0, 1, 2, 0};
   int exp_c[4] = '{0, 1, 1, 1};

   initial begin
      bus.dsp_ARID_i = '0; bus.dsp_ARADDR_i = '0; bus.dsp_ARLEN_i = '0;
      inputs_idle();
      model_reset();
      @(posedge clk); #1;
      do_reset();

      // Single request from master 1 with ARID 1
      bus.dsp_ARID_i[1*IDW +: IDW] = 5'd1;
      bus.dsp_ARVALID_i = 3'b010;
      bus.s_ARREADY_i   = 1'b1;
      step();
      chk("t1_grant", 64'(o_rdy), 64'b010);
      bus.dsp_ARVALID_i = '0;
      step();
      chk("t1_arid",  64'(o_arid), 64'b0100001);
      chk("t1_shift", 64'(o_shift), 64'd1);
      chk("t1_cross", 64'(o_cross), 64'd0);

      // All masters requesting: rotation and crossing flags
      do_reset();
      rand_payload();
      bus.dsp_ARVALID_i = '1;
      bus.s_ARREADY_i   = 1'b1;
      gq.delete(); cq.delete();
      for (int c = 0; c < 8; c++) begin
         step();
         if (o_win >= 0) gq.push_back(o_win);
         if (o_shift) cq.push_back(int'(o_cross));
      end
      chk("t2_ngrant", 64'(gq.size()), 64'd4);
      chk("t2_nshift", 64'(cq.size()), 64'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < gq.size()) chk("t2_order", 64'(gq[i]), 64'(exp_g[i]));
         if (i < cq.size()) chk("t2_cross", 64'(cq[i]), 64'(exp_c[i]));
      end

      // Slave backpressure holds the request
      do_reset();
      rand_payload();
      bus.dsp_ARVALID_i = 3'b100;
      step();
      chk("t3_grant", 64'(o_rdy), 64'b100);
      ref_id = bus.s_ARID_o;
      bus.dsp_ARVALID_i = 3'b001;
      ngr = 0; nsh = 0;
      for (int c = 0; c < 5; c++) begin
         step();
         if (o_rdy != 0) ngr++;
         if (o_shift) nsh++;
      end
      chk("t3_hold_grants", 64'(ngr), 64'd0);
      chk("t3_hold_shift",  64'(nsh), 64'd0);
      chk("t3_arid_hold",   64'(o_arid), 64'(ref_id));
      bus.dsp_ARVALID_i = '0;
      bus.s_ARREADY_i   = 1'b1;
      nsh = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (o_shift) nsh++;
      end
      chk("t3_release_shift", 64'(nsh), 64'd1);

      // Outstanding limit
      do_reset();
      rand_payload();
      bus.dsp_ARVALID_i = 3'b001;
      bus.s_ARREADY_i   = 1'b1;
      ngr = 0;
      for (int c = 0; c < 24; c++) begin
         step();
         if (o_rdy != 0) ngr++;
      end
      chk("t4_grants_cap", 64'(ngr), 64'(OUT));
      bus.s_RLAST_hs_i = 1'b1;
      step();
      chk("t4_retire_cycle", 64'(o_rdy), 64'd0);
      bus.s_RLAST_hs_i = 1'b0;
      step();
      chk("t4_regrant", 64'(o_rdy), 64'b001);

      // Ordering FIFO stall
      do_reset();
      rand_payload();
      bus.dsp_ARVALID_i = 3'b010;
      bus.AR_stall_i    = 1'b1;
      ngr = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (o_rdy != 0) ngr++;
      end
      chk("t5_stall_nogrant", 64'(ngr), 64'd0);
      bus.AR_stall_i = 1'b0;
      step();
      chk("t5_grant", 64'(o_rdy), 64'b010);
      bus.AR_stall_i  = 1'b1;
      bus.s_ARREADY_i = 1'b1;
      step();
      chk("t5_pending_done", 64'(o_shift), 64'd1);
      ngr = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (o_rdy != 0) ngr++;
      end
      chk("t5_stall_again", 64'(ngr), 64'd0);
      bus.AR_stall_i = 1'b0;
      step();
      chk("t5_resume", 64'(o_rdy), 64'b010);

      // Simultaneous issue and retire at three outstanding
      do_reset();
      rand_payload();
      bus.dsp_ARVALID_i = 3'b001;
      bus.s_ARREADY_i   = 1'b1;
      for (int c = 0; c < 7; c++) step();
      bus.s_RLAST_hs_i = 1'b1;
      step();
      chk("t6_hs_with_retire", 64'(o_shift), 64'd1);
      bus.s_RLAST_hs_i = 1'b0;
      ngr = 0;
      for (int c = 0; c < 30; c++) begin
         step();
         if (o_rdy != 0) ngr++;
      end
      chk("t6_grants_left", 64'(ngr), 64'd5);

      // Reset while a request is pending at the slave
      do_reset();
      rand_payload();
      bus.dsp_ARVALID_i = 3'b001;
      bus.s_ARREADY_i   = 1'b1;
      step();
      bus.dsp_ARVALID_i = 3'b010;
      step();
      bus.s_ARREADY_i = 1'b0;
      step();
      chk("t6_pre_reset_valid", 64'(bus.s_ARVALID_o), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid",   64'(bus.s_ARVALID_o), 64'd0);
      chk("t6_async_arready", 64'(bus.dsp_ARREADY_o), 64'd0);
      @(posedge clk); #1;
      inputs_idle();
      rst_n = 1'b1;
      model_reset();
      bus.dsp_ARVALID_i = 3'b100;
      bus.s_ARREADY_i   = 1'b1;
      step();
      bus.dsp_ARVALID_i = '0;
      step();
      chk("t6_post_reset_shift", 64'(o_shift), 64'd1);
      chk("t6_post_reset_cross", 64'(o_cross), 64'd0);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         rand_payload();
         bus.dsp_ARVALID_i = M'($urandom);
         bus.s_ARREADY_i   = ($urandom_range(0, 9) < 6);
         bus.s_RLAST_hs_i  = ($urandom_range(0, 9) < 3);
         bus.AR_stall_i    = ($urandom_range(0, 9) < 2);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
